pipe_stage_reg: RTL and testbench

- Parametrised inter-stage pipeline register for the 5-stage MIPS core.
- Replaces the fixed per-stage registers (D->E, E->M, M->W) with one block.
- Adds stall (hold), flush (bubble insertion), a valid bit, and automatic Tnew countdown per stage.
- Sits between any two adjacent pipeline stages; the hazard unit drives stall/flush.

---
 rtl/pipe_stage_reg.sv | 108 ++++++++++
 tb/tb_pipe_stage_reg.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register for the
// 5-stage MIPS core (D->E, E->M, M->W). Supports stall (hold), flush
// (bubble insertion), a valid bit and a per-stage Tnew countdown.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
  parameter int DATA_W           = 32,
  parameter int REG_AW           = 5,
  parameter int TNEW_W           = 2,
  parameter int TNEW_DEC         = 1,
  parameter int KEEP_PC_ON_FLUSH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [DATA_W-1:0] pc8_in,
  input  logic [DATA_W-1:0] v1_in,
  input  logic [DATA_W-1:0] v2_in,
  input  logic [DATA_W-1:0] ext_in,
  input  logic [REG_AW-1:0] a1_in,
  input  logic [REG_AW-1:0] a2_in,
  input  logic [REG_AW-1:0] a3_in,
  input  logic [TNEW_W-1:0] tnew_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] instr_out,
  output logic [DATA_W-1:0] pc8_out,
  output logic [DATA_W-1:0] v1_out,
  output logic [DATA_W-1:0] v2_out,
  output logic [DATA_W-1:0] ext_out,
  output logic [REG_AW-1:0] a1_out,
  output logic [REG_AW-1:0] a2_out,
  output logic [REG_AW-1:0] a3_out,
  output logic [TNEW_W-1:0] tnew_out
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  localparam logic [TNEW_W-1:0] DEC = TNEW_W'(TNEW_DEC);

  logic [TNEW_W-1:0] tnew_next;

  // Saturating Tnew countdown applied to the incoming instruction on load
  always_comb begin
    tnew_next = '0;
    if (tnew_in > DEC) begin
      tnew_next = tnew_in - DEC;
    end
  end

  // Stage register: reset > flush > stall > load
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      instr_out <= '0;
      pc8_out   <= '0;
      v1_out    <= '0;
      v2_out    <= '0;
      ext_out   <= '0;
      a1_out    <= '0;
      a2_out    <= '0;
      a3_out    <= '0;
      tnew_out  <= '0;
    end else if (flush) begin
      // Bubble: a3_out=0 keeps it from ever matching a forwarding source
      valid_out <= 1'b0;
      instr_out <= '0;
      pc8_out   <= (KEEP_PC_ON_FLUSH != 0) ? pc8_in : '0;
      v1_out    <= '0;
      v2_out    <= '0;
      ext_out   <= '0;
      a1_out    <= '0;
      a2_out    <= '0;
      a3_out    <= '0;
      tnew_out  <= '0;
    end else if (!stall) begin
      valid_out <= valid_in;
      instr_out <= instr_in;
      pc8_out   <= pc8_in;
      v1_out    <= v1_in;
      v2_out    <= v2_in;
      ext_out   <= ext_in;
      a1_out    <= a1_in;
      a2_out    <= a2_in;
      a3_out    <= a3_in;
      tnew_out  <= tnew_next;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  // Count held cycles and inserted bubbles; both wrap naturally at 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (flush) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end else if (stall) begin
      stall_cnt  <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: two instances (default parameters, and
// TNEW_DEC=0 / KEEP_PC_ON_FLUSH=0) share one stimulus stream. Expected
// register contents come from a rule-level model and are queued; a monitor
// compares after every rising edge. Define PIPE_STAGE_PERF_EN to also
// check the performance counters.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc8;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] ext;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  a3;
    logic [1:0]  tnew;
  } st_t;

  logic        clk = 1'b0;
  logic        reset, stall, flush, valid_in;
  logic [31:0] instr_in, pc8_in, v1_in, v2_in, ext_in;
  logic [4:0]  a1_in, a2_in, a3_in;
  logic [1:0]  tnew_in;

  logic        a_valid, b_valid;
  logic [31:0] a_instr, a_pc8, a_v1, a_v2, a_ext;
  logic [31:0] b_instr, b_pc8, b_v1, b_v2, b_ext;
  logic [4:0]  a_a1, a_a2, a_a3, b_a1, b_a2, b_a3;
  logic [1:0]  a_tnew, b_tnew;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] a_stall_cnt, a_bubble_cnt, b_stall_cnt, b_bubble_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stage_reg dut_a (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
    .instr_in(instr_in), .pc8_in(pc8_in), .v1_in(v1_in), .v2_in(v2_in), .ext_in(ext_in),
    .a1_in(a1_in), .a2_in(a2_in), .a3_in(a3_in), .tnew_in(tnew_in),
    .valid_out(a_valid), .instr_out(a_instr), .pc8_out(a_pc8), .v1_out(a_v1),
    .v2_out(a_v2), .ext_out(a_ext), .a1_out(a_a1), .a2_out(a_a2), .a3_out(a_a3),
    .tnew_out(a_tnew)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(a_stall_cnt), .bubble_cnt(a_bubble_cnt)
`endif
  );

  pipe_stage_reg #(.TNEW_DEC(0), .KEEP_PC_ON_FLUSH(0)) dut_b (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
    .instr_in(instr_in), .pc8_in(pc8_in), .v1_in(v1_in), .v2_in(v2_in), .ext_in(ext_in),
    .a1_in(a1_in), .a2_in(a2_in), .a3_in(a3_in), .tnew_in(tnew_in),
    .valid_out(b_valid), .instr_out(b_instr), .pc8_out(b_pc8), .v1_out(b_v1),
    .v2_out(b_v2), .ext_out(b_ext), .a1_out(b_a1), .a2_out(b_a2), .a3_out(b_a3),
    .tnew_out(b_tnew)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(b_stall_cnt), .bubble_cnt(b_bubble_cnt)
`endif
  );

  st_t act_a, act_b;
  assign act_a = {a_valid, a_instr, a_pc8, a_v1, a_v2, a_ext, a_a1, a_a2, a_a3, a_tnew};
  assign act_b = {b_valid, b_instr, b_pc8, b_v1, b_v2, b_ext, b_a1, b_a2, b_a3, b_tnew};

  st_t         q_a[$];
  st_t         q_b[$];
  logic [63:0] q_perf[$];
  int          checks   = 0;
  int          failures = 0;
  int          cycle    = 0;

  st_t         cur_a = '0;
  st_t         cur_b = '0;
  logic [31:0] m_stall  = '0;
  logic [31:0] m_bubble = '0;

  // What a pipeline register should hold after one edge, from its rules
  function automatic st_t model(st_t cur, bit rst, bit fl, bit stl, st_t in,
                                int dec, bit keep_pc);
    st_t r;
    int  t;
    if (rst) return '0;
    if (fl) begin
      r = '0;
      if (keep_pc) r.pc8 = in.pc8;
      return r;
    end
    if (stl) return cur;
    r = in;
    t = int'(in.tnew) - dec;
    if (t < 0) t = 0;
    r.tnew = 2'(t);
    return r;
  endfunction

  function automatic st_t rnd_p();
    st_t p;
    p.valid = 1'($urandom);
    p.instr = $urandom;
    p.pc8   = $urandom;
    p.v1    = $urandom;
    p.v2    = $urandom;
    p.ext   = $urandom;
    p.a1    = 5'($urandom);
    p.a2    = 5'($urandom);
    p.a3    = 5'($urandom);
    p.tnew  = 2'($urandom);
    return p;
  endfunction

  task automatic step(input bit rst, input bit stl, input bit fl, input st_t p);
    @(negedge clk);
    reset = rst;
    stall = stl;
    flush = fl;
    {valid_in, instr_in, pc8_in, v1_in, v2_in, ext_in, a1_in, a2_in, a3_in, tnew_in} = p;
    cur_a = model(cur_a, rst, fl, stl, p, 1, 1'b1);
    cur_b = model(cur_b, rst, fl, stl, p, 0, 1'b0);
    q_a.push_back(cur_a);
    q_b.push_back(cur_b);
    if (rst) begin
      m_stall  = '0;
      m_bubble = '0;
    end else if (fl) begin
      m_bubble = m_bubble + 32'd1;
    end else if (stl) begin
      m_stall = m_stall + 32'd1;
    end
    q_perf.push_back({m_stall, m_bubble});
  endtask

  // Monitor: compare register contents just after every rising edge
  always @(posedge clk) begin
    st_t         e;
    logic [63:0] ep;
    #1;
    cycle++;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      checks++;
      if (act_a !== e) begin
        failures++;
        $display("FAIL dut_a cycle %0d: got %h expected %h", cycle, act_a, e);
      end
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      checks++;
      if (act_b !== e) begin
        failures++;
        $display("FAIL dut_b cycle %0d: got %h expected %h", cycle, act_b, e);
      end
    end
    if (q_perf.size() > 0) begin
      ep = q_perf.pop_front();
`ifdef PIPE_STAGE_PERF_EN
      checks++;
      if ({a_stall_cnt, a_bubble_cnt} !== ep || {b_stall_cnt, b_bubble_cnt} !== ep) begin
        failures++;
        $display("FAIL perf cycle %0d: got stall=%0d bubble=%0d expected stall=%0d bubble=%0d",
                 cycle, a_stall_cnt, a_bubble_cnt, ep[63:32], ep[31:0]);
      end
`endif
    end
  end

  initial begin
    st_t p;
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    {valid_in, instr_in, pc8_in, v1_in, v2_in, ext_in, a1_in, a2_in, a3_in, tnew_in} = '0;

    // Reset then a load instruction
    step(1, 0, 0, rnd_p());
    p = rnd_p(); p.valid = 1; p.instr = 32'h8C22_0004; p.pc8 = 32'h0000_3008;
    p.a3 = 5'd2; p.tnew = 2'd2;
    step(0, 0, 0, p);

    // Tnew saturation boundaries
    p = rnd_p(); p.tnew = 2'd0; step(0, 0, 0, p);
    p = rnd_p(); p.tnew = 2'd3; step(0, 0, 0, p);
    p = rnd_p(); p.tnew = 2'd1; step(0, 0, 0, p);

    // Stall hold for three cycles, then release
    p = rnd_p(); p.valid = 1; p.v1 = 32'h1111_1111; step(0, 0, 0, p);
    p.v1 = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) step(0, 1, 0, p);
    step(0, 0, 0, p);

    // Flush together with stall
    p = rnd_p(); p.valid = 1; p.a3 = 5'd5; p.pc8 = 32'h0000_3010;
    step(0, 1, 1, p);

    // Reset during stall discards the held instruction
    p = rnd_p(); p.valid = 1; step(0, 0, 0, p);
    step(0, 1, 0, rnd_p());
    step(1, 1, 0, rnd_p());
    p = rnd_p(); p.valid = 1; step(0, 0, 0, p);

    // Invalid instruction still copies payload
    p = rnd_p(); p.valid = 0; step(0, 0, 0, p);

    // Counter pattern: 4 stalls, 2 flushes, 1 stall+flush after a reset
    step(1, 0, 0, rnd_p());
    for (int i = 0; i < 4; i++) step(0, 1, 0, rnd_p());
    for (int i = 0; i < 2; i++) step(0, 0, 1, rnd_p());
    step(0, 1, 1, rnd_p());

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 25),
           ($urandom_range(0, 99) < 12), rnd_p());
    end

    // Drain: every queued expectation must be consumed within a few edges
    repeat (4) @(negedge clk);
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", q_a.size(), q_b.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
